// File: rtl/debounce_pb_multi.sv
// N-channel debouncer for active-low push-buttons: a 2-flop synchroniser, a
// stability-window filter and registered press/release strobes per channel.
// Optional auto-repeat on held buttons is enabled by defining DEBOUNCE_REPEAT_EN.
module debounce_pb_multi #(
    parameter int N_CH        = 4,
    parameter int STABLE_CLKS = 500000,
    parameter int CNT_W       = $clog2(STABLE_CLKS + 1),
    parameter int HOLD_CLKS   = 25000000,
    parameter int REPEAT_CLKS = 5000000
) (
    input  logic            in_clk,
    input  logic            in_rst_n,
    input  logic [N_CH-1:0] pb_in,
    output logic [N_CH-1:0] pb_out,
    output logic [N_CH-1:0] pb_press,
    output logic [N_CH-1:0] pb_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CLKS - 1);

    // Elaboration-time sanity checks on the configuration.
    if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
        $error("debounce_pb_multi: N_CH must be in 1..16");
    end
    if (STABLE_CLKS < 2) begin : g_bad_stable
        $error("debounce_pb_multi: STABLE_CLKS must be >= 2");
    end
    if (HOLD_CLKS < 1 || REPEAT_CLKS < 1) begin : g_bad_repeat
        $error("debounce_pb_multi: HOLD_CLKS and REPEAT_CLKS must be >= 1");
    end

    logic [N_CH-1:0] sync1_reg;
    logic [N_CH-1:0] sync2_reg;

    // Pins idle high, so the synchroniser resets to "not pressed".
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= pb_in;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             out_reg;
            logic             out_next;
            logic             press_reg;
            logic             release_reg;
            logic             differ;
            logic             accept;
            logic             press_next;

            assign differ = sync2_reg[gi] ^ out_reg;
            assign accept = differ && (cnt_reg == CNT_LAST);

            // Any sample matching the accepted level restarts the window.
            always_comb begin
                cnt_next = cnt_reg;
                out_next = out_reg;
                if (!differ) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    out_next = sync2_reg[gi];
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

`ifdef DEBOUNCE_REPEAT_EN
            localparam int HOLD_MAX = (HOLD_CLKS > REPEAT_CLKS) ? HOLD_CLKS : REPEAT_CLKS;
            localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
            localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CLKS - 1);
            localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CLKS - 1);

            logic [HOLD_W-1:0] hold_reg;
            logic              rep_mode_reg;
            logic              rep_fire;

            // A release being accepted this edge suppresses any repeat pulse.
            assign rep_fire = !out_reg && !accept &&
                              (hold_reg == (rep_mode_reg ? REP_LAST : HOLD_LAST));

            always_ff @(posedge in_clk or negedge in_rst_n) begin
                if (!in_rst_n) begin
                    hold_reg     <= '0;
                    rep_mode_reg <= 1'b0;
                end else if (out_reg || accept) begin
                    hold_reg     <= '0;
                    rep_mode_reg <= 1'b0;
                end else if (rep_fire) begin
                    hold_reg     <= '0;
                    rep_mode_reg <= 1'b1;
                end else begin
                    hold_reg     <= hold_reg + 1'b1;
                end
            end

            assign press_next = (accept && out_reg) || rep_fire;
`else
            assign press_next = accept && out_reg;
`endif

            always_ff @(posedge in_clk or negedge in_rst_n) begin
                if (!in_rst_n) begin
                    cnt_reg     <= '0;
                    out_reg     <= 1'b1;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    cnt_reg     <= cnt_next;
                    out_reg     <= out_next;
                    press_reg   <= press_next;
                    release_reg <= accept && !out_reg;
                end
            end

            assign pb_out[gi]     = out_reg;
            assign pb_press[gi]   = press_reg;
            assign pb_release[gi] = release_reg;
        end
    endgenerate

endmodule

// File: doc/debounce_pb_multi.md
Name: debounce_pb_multi

Overview:
- Parametrised successor to the single-button debouncer: debounces N active-low push-buttons in parallel, one independent filter per channel.
- Adds per-input 2-flop synchronisers, a programmable stability window, and one-cycle press/release strobes.
- Sits between the board pins (paddle up/down, start, reset-game buttons) and the pong game control FSM.
- Game logic consumes either the clean level or the strobes.

Parameters:
- N_CH, 4, number of button channels (1..16).
- STABLE_CLKS, 500000, consecutive clocks a new level must persist before it is accepted (10 ms at 50 MHz); must be >= 2.
- CNT_W, $clog2(STABLE_CLKS+1), counter width per channel (derived; do not override).
- HOLD_CLKS, 25000000, clocks held before auto-repeat starts (0.5 s); used only with DEBOUNCE_REPEAT_EN.
- REPEAT_CLKS, 5000000, auto-repeat period (0.1 s); used only with DEBOUNCE_REPEAT_EN.

Ports:
- in_clk  input  1  system clock.
- in_rst_n  input  1  asynchronous, active-low reset.
- pb_in  input  N_CH  raw button pins, active-low (0 = pressed), asynchronous to in_clk.
- pb_out  output  N_CH  debounced level, same polarity as pb_in.
- pb_press  output  N_CH  one-cycle strobe per channel when pb_out goes 1->0.
- pb_release  output  N_CH  one-cycle strobe per channel when pb_out goes 0->1.

Behaviour:
- Reset:
  - Asserting in_rst_n=0 asynchronously forces all synchroniser flops to 1, pb_out to all-ones (not pressed), all counters to 0, and pb_press/pb_release to 0.
  - Release of reset is synchronous to the next in_clk edge.
  - Reset mid-count discards the count; no strobe is issued for the reset itself.
- Synchroniser: each pb_in bit passes through 2 flops (s1, s2). Only s2 is used downstream.
- Per-channel filter, evaluated each in_clk edge:
  - s2 == pb_out[i]: counter <= 0.
  - s2 != pb_out[i] and counter < STABLE_CLKS-1: counter <= counter+1.
  - s2 != pb_out[i] and counter == STABLE_CLKS-1: pb_out[i] <= s2, counter <= 0.
- Any glitch back to the accepted level before the window completes clears the counter. Accumulation is never partial.
- Latency: a clean step on pb_in appears on pb_out exactly 2+STABLE_CLKS in_clk edges later.
- Strobes: pb_press[i] is high for exactly the cycle after pb_out[i] falls; pb_release[i] for exactly the cycle after it rises. Press and release are never high together on one channel.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous strobes, with no arbitration.
- Counter saturation is impossible: the counter is cleared on acceptance, so there is no wrap-around.
- Input bouncing faster than STABLE_CLKS never changes pb_out.

Optional Feature:
- Macro: DEBOUNCE_REPEAT_EN.
- Defined: each channel gains a hold counter that is cleared whenever pb_out[i]==1 or on a press strobe.
  - While pressed, after HOLD_CLKS clocks pb_press[i] pulses for 1 cycle.
  - Further 1-cycle pulses follow every REPEAT_CLKS clocks until release.
  - Release stops repetition immediately; no repeat pulse coincides with pb_release.
  - Allows continuous paddle movement when a button is held.
- Undefined: no hold/repeat logic is generated; pb_press fires once per accepted press. HOLD_CLKS and REPEAT_CLKS are ignored.

Test Plan:
- All scenarios use STABLE_CLKS=8, N_CH=4.
- Reset: hold in_rst_n=0 with pb_in=4'b0000 -> pb_out=4'b1111, strobes 0. Release reset, keep pb_in=0 -> pb_out[3:0]=0 at edge 10, one pb_press=4'b1111 pulse.
- Clean press ch0: pb_in[0] 1->0 and held -> pb_out[0] falls exactly 10 edges later; pb_press[0]=1 for 1 cycle; other channels unchanged.
- Bounce ch1: pb_in[1] toggles every 3 clocks for 60 clocks, then stays 0 -> pb_out[1] stays 1 through the bouncing; falls 10 edges after the final settle; exactly one pb_press[1].
- Glitch reject: 7-cycle low pulse on ch2 -> no change, no strobe. 8-cycle low pulse -> pb_out[2] low for 8+ cycles, then pb_press[2] and pb_release[2] once each.
- Async reset mid-count: assert in_rst_n=0 at count 5 on ch3 -> pb_out[3]=1 immediately, counter 0, no strobe after release if pb_in[3]=1.
- DEBOUNCE_REPEAT_EN (HOLD_CLKS=20, REPEAT_CLKS=6): hold ch0 low for 50 clocks after acceptance -> pb_press[0] pulses at +0, +20, +26, +32, +38, +44, +50; release -> pb_release[0] once, no further pulses.
